// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, FSM states, field positions.
package alu_seq_ctrl_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD      = 4'b0000;
  localparam logic [3:0] OP_SUB      = 4'b0010;
  localparam logic [3:0] OP_DIV      = 4'b0111;
  localparam logic [3:0] OP_ALU_LAST = 4'b1001;
  localparam logic [3:0] OP_CMP      = 4'b1010;
  localparam logic [3:0] OP_LD       = 4'b1011;
  localparam logic [3:0] OP_BR       = 4'b1100;
  localparam logic [3:0] OP_NOP0     = 4'b1101;
  localparam logic [3:0] OP_NOP1     = 4'b1110;
  localparam logic [3:0] OP_HALT     = 4'b1111;

  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 12;
  localparam int RA_MSB      = 11;
  localparam int RA_LSB      = 9;
  localparam int RB_MSB      = 2;
  localparam int RB_LSB      = 0;
  localparam int MODE_BIT    = 8;
  localparam int IMM_SEL_BIT = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DIVWAIT,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
    return {{(DATA_W-5){v[4]}}, v};
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction classifier; also produces the opcode word presented to the ALU.
module alu_seq_decode
  import alu_seq_ctrl_pkg::*;
#(
  parameter bit DIV_EN = 1'b0
) (
  input  logic [15:0] i_instr,
  output logic        o_writes_rf,
  output logic        o_sets_flags,
  output logic        o_is_branch,
  output logic        o_is_ld,
  output logic        o_is_div,
  output logic        o_is_halt,
  output logic [15:0] o_alu_opcode
);

  logic [3:0] w_op;
  assign w_op = i_instr[OP_MSB:OP_LSB];

  always_comb begin
    o_writes_rf  = 1'b0;
    o_sets_flags = 1'b0;
    o_is_branch  = 1'b0;
    o_is_ld      = 1'b0;
    o_is_div     = 1'b0;
    o_is_halt    = 1'b0;
    o_alu_opcode = i_instr;
    case (w_op)
      OP_DIV: begin
        o_is_div     = 1'b1;
        o_writes_rf  = DIV_EN;
        o_sets_flags = DIV_EN;
      end
      // Compare reuses the register-register subtract path
      OP_CMP: begin
        o_sets_flags = 1'b1;
        o_alu_opcode = {OP_SUB, i_instr[11:6], 1'b0, i_instr[4:0]};
      end
      OP_LD: begin
        o_is_ld     = 1'b1;
        o_writes_rf = 1'b1;
      end
      OP_BR:   o_is_branch = 1'b1;
      OP_HALT: o_is_halt   = 1'b1;
      default: begin
        if (w_op <= OP_ALU_LAST) begin
          o_writes_rf  = 1'b1;
          o_sets_flags = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit ALU datapath.
// Define ALU_DIV_EN to enable the multi-cycle external divide (DIVWAIT state).
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic [2:0]  rf_raddr_a,
  output logic [2:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [15:0] alu_opcode,
  output logic [15:0] alu_rega,
  output logic [15:0] alu_regb,
  output logic [15:0] alu_imm,
  input  logic [15:0] alu_res,
  output logic        div_start,
  input  logic        div_done,
  output logic [15:0] ip,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_p,
  output logic        halted
);

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  state_t      r_state;
  logic [15:0] r_instr;
  logic [15:0] r_ip;
  logic [2:0]  r_nzp;
  logic        r_imem_req;
  logic [15:0] r_imem_addr;
  logic [2:0]  r_raddr_a;
  logic [2:0]  r_raddr_b;
  logic        r_rf_we;
  logic [2:0]  r_waddr;
  logic [15:0] r_wdata;
  logic [15:0] r_alu_opcode;
  logic [15:0] r_alu_rega;
  logic [15:0] r_alu_regb;
  logic [15:0] r_alu_imm;
  logic        r_div_start;
  logic        r_halted;

  logic        w_writes_rf;
  logic        w_sets_flags;
  logic        w_is_branch;
  logic        w_is_ld;
  logic        w_is_div;
  logic        w_is_halt;
  logic [15:0] w_alu_op;
  logic [15:0] w_ip_inc;
  logic [15:0] w_br_tgt;
  logic        w_br_taken;
  logic [15:0] w_exec_res;
  logic [15:0] w_commit_res;
  logic        w_commit;

  alu_seq_decode #(.DIV_EN(DIV_EN)) u_decode (
    .i_instr      (r_instr),
    .o_writes_rf  (w_writes_rf),
    .o_sets_flags (w_sets_flags),
    .o_is_branch  (w_is_branch),
    .o_is_ld      (w_is_ld),
    .o_is_div     (w_is_div),
    .o_is_halt    (w_is_halt),
    .o_alu_opcode (w_alu_op)
  );

  function automatic logic [2:0] nzp_of(input logic [15:0] res);
    if (res[15])           return 3'b100;
    else if (res == 16'h0) return 3'b010;
    else                   return 3'b001;
  endfunction

  assign w_ip_inc   = r_ip + 16'd1;
  assign w_br_tgt   = w_ip_inc + {{7{r_instr[8]}}, r_instr[8:0]};
  assign w_br_taken = |(r_instr[RA_MSB:RA_LSB] & r_nzp);
  assign w_exec_res = w_is_ld ? (r_instr[MODE_BIT] ? r_alu_regb : {8'h00, r_instr[7:0]})
                              : alu_res;
  assign w_commit_res = (r_state == S_DIVWAIT) ? alu_res : w_exec_res;
  // Architectural state (ip, flags, register write) changes only on entry to WB
  assign w_commit = ((r_state == S_EXEC) && !(DIV_EN && w_is_div)) ||
                    ((r_state == S_DIVWAIT) && div_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_instr      <= '0;
      r_ip         <= RESET_IP;
      r_nzp        <= 3'b010;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= '0;
      r_raddr_a    <= '0;
      r_raddr_b    <= '0;
      r_rf_we      <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_alu_opcode <= '0;
      r_alu_rega   <= '0;
      r_alu_regb   <= '0;
      r_alu_imm    <= '0;
      r_div_start  <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_rf_we     <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_FETCH;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_ip;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            r_state    <= S_DECODE;
            r_imem_req <= 1'b0;
            r_instr    <= imem_rdata;
            r_raddr_a  <= imem_rdata[RA_MSB:RA_LSB];
            r_raddr_b  <= imem_rdata[RB_MSB:RB_LSB];
          end
        end
        S_DECODE: begin
          if (w_is_halt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state      <= S_EXEC;
            r_alu_opcode <= w_alu_op;
            r_alu_rega   <= rf_rdata_a;
            r_alu_regb   <= rf_rdata_b;
            r_alu_imm    <= sext5(r_instr[4:0]);
          end
        end
        S_EXEC: begin
          if (DIV_EN && w_is_div) begin
            r_state     <= S_DIVWAIT;
            r_div_start <= 1'b1;
          end
        end
        S_WB: begin
          r_state     <= S_FETCH;
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_ip;
        end
        default: ;
      endcase
      if (w_commit) begin
        r_state <= S_WB;
        r_ip    <= (w_is_branch && w_br_taken) ? w_br_tgt : w_ip_inc;
        if (w_writes_rf) begin
          r_rf_we <= 1'b1;
          r_waddr <= r_instr[RA_MSB:RA_LSB];
          r_wdata <= w_commit_res;
        end
        if (w_sets_flags) r_nzp <= nzp_of(w_commit_res);
      end
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign rf_raddr_a = r_raddr_a;
  assign rf_raddr_b = r_raddr_b;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign alu_opcode = r_alu_opcode;
  assign alu_rega   = r_alu_rega;
  assign alu_regb   = r_alu_regb;
  assign alu_imm    = r_alu_imm;
  assign div_start  = r_div_start;
  assign ip         = r_ip;
  assign flag_n     = r_nzp[2];
  assign flag_z     = r_nzp[1];
  assign flag_p     = r_nzp[0];
  assign halted     = r_halted;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: LD, ALU/CMP flags, branches, memory wait, DIV, mid-op reset, HALT.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [2:0]  rf_raddr_a, rf_raddr_b;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] alu_opcode, alu_rega, alu_regb, alu_imm;
  logic [15:0] alu_res;
  logic        div_start;
  logic        div_done;
  logic [15:0] ip;
  logic        flag_n, flag_z, flag_p;
  logic        halted;

  logic [15:0] rf [8];
  int total = 0;
  int bad   = 0;

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always #5 clk = ~clk;

  alu_seq_ctrl #(.RESET_IP(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_rdata_a (rf_rdata_a),
    .rf_rdata_b (rf_rdata_b),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .alu_opcode (alu_opcode),
    .alu_rega   (alu_rega),
    .alu_regb   (alu_regb),
    .alu_imm    (alu_imm),
    .alu_res    (alu_res),
    .div_start  (div_start),
    .div_done   (div_done),
    .ip         (ip),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_p     (flag_p),
    .halted     (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one fetch: wait for imem_req, stall wt cycles, then deliver the word.
  // Returns in the DECODE cycle with the number of cycles imem_req was seen high.
  task automatic run_instr(input logic [15:0] word, input int wt, output int req_cycles);
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      step();
      n++;
    end
    if (!imem_req) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout imem_req=%b want 1", imem_req);
    end
    req_cycles = 0;
    for (int i = 0; i < wt; i++) begin
      imem_valid = 1'b0;
      if (imem_req) req_cycles++;
      step();
    end
    if (imem_req) req_cycles++;
    imem_valid = 1'b1;
    imem_rdata = word;
    step();
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  task automatic run_to_wb(input logic [15:0] word);
    int rc;
    run_instr(word, 0, rc);
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (ip !== 16'h0000) begin bad++; $display("FAIL reset_ip got=%h want=0000", ip); end
    total++; if ({flag_n, flag_z, flag_p} !== 3'b010) begin bad++; $display("FAIL reset_flags got=%b want=010", {flag_n, flag_z, flag_p}); end
    total++; if ({imem_req, rf_we, div_start, halted} !== 4'b0000) begin bad++; $display("FAIL reset_strobes got=%b want=0000", {imem_req, rf_we, div_start, halted}); end
    total++; if ({alu_opcode, alu_rega, imem_addr} !== 48'h0) begin bad++; $display("FAIL reset_outs got=%h want=0", {alu_opcode, alu_rega, imem_addr}); end
    rst_n = 1'b1;
    step();
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b want=0", imem_req); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL first_fetch got=%b/%h want=1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_ld();
    run_to_wb(16'hB105);
    total++; if ({rf_we, rf_waddr} !== 4'b1000 || rf_wdata !== 16'h0005) begin bad++; $display("FAIL ld_b105 got we=%b a=%0d d=%h want 1/0/0005", rf_we, rf_waddr, rf_wdata); end
    total++; if (ip !== 16'h0001 || {flag_n, flag_z, flag_p} !== 3'b010) begin bad++; $display("FAIL ld_b105_ipflags got=%h/%b want=0001/010", ip, {flag_n, flag_z, flag_p}); end
    step();
    total++; if (rf_we !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin bad++; $display("FAIL ld_next_fetch got we=%b req=%b addr=%h want 0/1/0001", rf_we, imem_req, imem_addr); end
    run_to_wb(16'hB0A5);
    total++; if (rf_wdata !== 16'h00A5 || rf_waddr !== 3'd0) begin bad++; $display("FAIL ld_imm got=%h/%0d want=00A5/0", rf_wdata, rf_waddr); end
    run_to_wb(16'hB303);
    total++; if (rf_wdata !== 16'h1234 || rf_waddr !== 3'd1 || ip !== 16'h0003) begin bad++; $display("FAIL ld_reg got=%h/%0d/%h want=1234/1/0003", rf_wdata, rf_waddr, ip); end
  endtask

  task automatic test_alu();
    int rc;
    alu_res = 16'h8000;
    run_instr(16'h0632, 0, rc);
    total++; if (rf_raddr_a !== 3'd3 || rf_raddr_b !== 3'd2) begin bad++; $display("FAIL alu_raddr got=%0d/%0d want=3/2", rf_raddr_a, rf_raddr_b); end
    step();
    total++; if (alu_imm !== 16'hFFF2 || alu_opcode !== 16'h0632) begin bad++; $display("FAIL alu_imm got=%h/%h want=FFF2/0632", alu_imm, alu_opcode); end
    step();
    total++; if ({rf_we, rf_waddr} !== 4'b1011 || rf_wdata !== 16'h8000 || {flag_n, flag_z, flag_p} !== 3'b100) begin bad++; $display("FAIL alu_neg got we=%b a=%0d d=%h f=%b want 1/3/8000/100", rf_we, rf_waddr, rf_wdata, {flag_n, flag_z, flag_p}); end
    alu_res = 16'h0000;
    run_instr(16'h0202, 0, rc);
    step();
    total++; if (alu_rega !== 16'h0007 || alu_regb !== 16'hFFF9) begin bad++; $display("FAIL add_operands got=%h/%h want=0007/FFF9", alu_rega, alu_regb); end
    step();
    total++; if ({rf_we, rf_waddr} !== 4'b1001 || rf_wdata !== 16'h0000 || {flag_n, flag_z, flag_p} !== 3'b010) begin bad++; $display("FAIL add_zero got we=%b a=%0d d=%h f=%b want 1/1/0000/010", rf_we, rf_waddr, rf_wdata, {flag_n, flag_z, flag_p}); end
    alu_res = 16'h000E;
    run_instr(16'hA022, 0, rc);
    step();
    total++; if (alu_opcode !== 16'h2002) begin bad++; $display("FAIL cmp_opcode got=%h want=2002", alu_opcode); end
    step();
    total++; if (rf_we !== 1'b0 || {flag_n, flag_z, flag_p} !== 3'b001 || ip !== 16'h0006) begin bad++; $display("FAIL cmp_flags got we=%b f=%b ip=%h want 0/001/0006", rf_we, {flag_n, flag_z, flag_p}, ip); end
    alu_res = 16'h8000;
    run_to_wb(16'hB080);
    total++; if (rf_wdata !== 16'h0080 || {flag_n, flag_z, flag_p} !== 3'b001) begin bad++; $display("FAIL ld_keeps_flags got=%h/%b want=0080/001", rf_wdata, {flag_n, flag_z, flag_p}); end
  endtask

  task automatic test_branch();
    alu_res = 16'h8000;
    run_to_wb(16'h0632);
    run_to_wb(16'hCE07);
    total++; if (ip !== 16'h0010 || rf_we !== 1'b0) begin bad++; $display("FAIL br_always got=%h/%b want=0010/0", ip, rf_we); end
    run_to_wb(16'hC9FD);
    step();
    total++; if (imem_addr !== 16'h000E) begin bad++; $display("FAIL br_n_taken got=%h want=000E", imem_addr); end
    alu_res = 16'h000E;
    run_to_wb(16'hA022);
    run_to_wb(16'hCE00);
    total++; if (ip !== 16'h0010) begin bad++; $display("FAIL br_zero_off got=%h want=0010", ip); end
    run_to_wb(16'hC9FD);
    step();
    total++; if (imem_addr !== 16'h0011 || {flag_n, flag_z, flag_p} !== 3'b001) begin bad++; $display("FAIL br_not_taken got=%h/%b want=0011/001", imem_addr, {flag_n, flag_z, flag_p}); end
    run_to_wb(16'hCFED);
    total++; if (ip !== 16'hFFFF) begin bad++; $display("FAIL br_back got=%h want=FFFF", ip); end
    run_to_wb(16'hD000);
    total++; if (ip !== 16'h0000 || rf_we !== 1'b0) begin bad++; $display("FAIL ip_wrap got=%h/%b want=0000/0", ip, rf_we); end
  endtask

  task automatic test_wait();
    int rc, cyc, we_cnt, n;
    run_instr(16'hB0A5, 5, rc);
    cyc = rc;
    we_cnt = 0;
    n = 0;
    do begin
      cyc++;
      step();
      if (rf_we) we_cnt++;
      n++;
    end while (!imem_req && n < 20);
    total++; if (rc !== 6) begin bad++; $display("FAIL wait_req_cycles got=%0d want=6", rc); end
    total++; if (cyc !== 9) begin bad++; $display("FAIL wait_latency got=%0d want=9", cyc); end
    total++; if (we_cnt !== 1 || ip !== 16'h0001) begin bad++; $display("FAIL wait_once got we_cnt=%0d ip=%h want 1/0001", we_cnt, ip); end
  endtask

  task automatic test_div();
    int rc, ds_cnt, n;
    ds_cnt = 0;
    alu_res = 16'h8003;
`ifdef ALU_DIV_EN
    run_instr(16'h7403, 0, rc);
    step();
    if (div_start) ds_cnt++;
    step();
    n = 1;
    total++; if (div_start !== 1'b1) begin bad++; $display("FAIL div_start_pulse got=%b want=1", div_start); end
    ds_cnt++;
    while (n < 17) begin
      step();
      n++;
      if (div_start) ds_cnt++;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL div_early_we cycle=%0d got=%b want=0", n, rf_we); end
    end
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    if (div_start) ds_cnt++;
    total++; if ({rf_we, rf_waddr} !== 4'b1010 || rf_wdata !== 16'h8003 || {flag_n, flag_z, flag_p} !== 3'b100) begin bad++; $display("FAIL div_wb got we=%b a=%0d d=%h f=%b want 1/2/8003/100", rf_we, rf_waddr, rf_wdata, {flag_n, flag_z, flag_p}); end
    total++; if (ds_cnt !== 1 || ip !== 16'h0002) begin bad++; $display("FAIL div_count got=%0d ip=%h want 1/0002", ds_cnt, ip); end
`else
    div_done = 1'b1;
    run_instr(16'h7403, 0, rc);
    if (div_start) ds_cnt++;
    step();
    if (div_start) ds_cnt++;
    step();
    if (div_start) ds_cnt++;
    total++; if (rf_we !== 1'b0 || ip !== 16'h0002 || {flag_n, flag_z, flag_p} !== 3'b001) begin bad++; $display("FAIL div_nop got we=%b ip=%h f=%b want 0/0002/001", rf_we, ip, {flag_n, flag_z, flag_p}); end
    step();
    div_done = 1'b0;
    total++; if (ds_cnt !== 0 || imem_req !== 1'b1) begin bad++; $display("FAIL div_off_start got=%0d req=%b want 0/1", ds_cnt, imem_req); end
`endif
  endtask

  task automatic test_reset_mid();
    int rc;
    alu_res = 16'h1234;
`ifdef ALU_DIV_EN
    run_instr(16'h7403, 0, rc);
    step();
    step();
`else
    run_instr(16'h0202, 0, rc);
    step();
`endif
    rst_n = 1'b0;
    #1;
    total++; if (ip !== 16'h0000 || {flag_n, flag_z, flag_p} !== 3'b010) begin bad++; $display("FAIL rst_mid_state got=%h/%b want=0000/010", ip, {flag_n, flag_z, flag_p}); end
    total++; if ({rf_we, imem_req, div_start} !== 3'b000 || alu_opcode !== 16'h0000) begin bad++; $display("FAIL rst_mid_outs got=%b/%h want=000/0000", {rf_we, imem_req, div_start}, alu_opcode); end
    step();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_mid_nowrite got=%b want=0", rf_we); end
    rst_n = 1'b1;
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%b want=0", imem_req); end
  endtask

  task automatic test_halt();
    int rc;
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(16'hF000, 0, rc);
    step();
    total++; if (halted !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL halt_enter got=%b/%b want=1/0", halted, imem_req); end
    start = 1'b1;
    step();
    step();
    step();
    start = 1'b0;
    total++; if (halted !== 1'b1 || imem_req !== 1'b0 || ip !== 16'h0000) begin bad++; $display("FAIL halt_sticky got=%b/%b/%h want=1/0/0000", halted, imem_req, ip); end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    alu_res    = 16'h0000;
    div_done   = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    rf[1] = 16'h0007;
    rf[2] = 16'hFFF9;
    rf[3] = 16'h1234;
    rf[5] = 16'h0005;
    test_reset();
    test_ld();
    test_alu();
    test_branch();
    test_wait();
    test_div();
    test_reset_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
